alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle control FSM that sequences the ALU for the d16 core: fetches the
//  instruction word (and optional immediate word), pulses the ALU enable, runs the
//  LD/ST/PUSH/POP memory phase and commits register file / PC / SP / flags updates.
//  Sits between the single-port memory bus and the ALU + register file.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
//  SP_REG     3'd7      register index used as stack pointer for PUSH/POP
// PORTS
//  clk          in   1   core clock
//  rst          in   1   asynchronous active-high reset
//  mem_addr     out  16  memory address (PC in fetch; ALU out in memory phase)
//  mem_req      out  1   request; held until mem_ack
//  mem_we       out  1   write strobe, valid with mem_req
//  mem_ack      in   1   one-cycle completion pulse; rdata valid the same cycle
//  mem_rdata    in   16  memory read data
//  alu_en       out  1   one-cycle ALU enable
//  alu_control  out  8   opcode to ALU (instr[7:0])
//  en_imm       out  1   instr[8]; immediate word follows instruction
//  mem_disp     out  1   instr[15]; address = rS + immediate
//  rd_sel       out  3   instr[14:12]
//  rs_sel       out  3   instr[11:9] (forced to SP_REG for PUSH/POP)
//  immediate    out  16  latched immediate word
//  alu_out      in   16  ALU result
//  alu_write    in   1   ALU write-back request
//  alu_branch   in   1   ALU should_branch
//  alu_sp       in   16  ALU SP_out
//  reg_we       out  1   register-file write strobe (one cycle)
//  reg_wsel     out  3   register-file write index
//  reg_wdata    out  16  register-file write data
//  flags_we     out  1   flags register load strobe
//  pc           out  16  program counter
//  fault        out  1   sticky illegal-opcode indicator (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=FETCH, pc=RESET_PC, all strobes 0, immediate=0, fault=0.
//  States: FETCH -> (en_imm ? IMM : EXEC) -> EXEC -> RESULT -> (MEM | WB) -> FETCH.
//  FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack latch instr, pc+=2.
//  IMM: as FETCH, latch word into immediate, pc+=2.
//  EXEC: alu_en=1 for exactly one cycle; ALU result is valid in RESULT.
//  RESULT: LD/ST/PUSH/POP -> MEM; all others -> WB.
//  MEM: mem_addr=alu_out; mem_we=1 for ST/PUSH, 0 for LD/POP; wait for mem_ack;
//   mem_req stays high and address stable while waiting (no timeout).
//  WB (1 cycle): reg_we=alu_write; wsel=rd_sel; wdata=alu_out, or mem_rdata latched
//   in MEM for LD/POP. flags_we=1 for ADD/SUB/ADC/SBB/CMP/AND/OR/XOR/NOT/NEG/SHL/SHR.
//   PUSH/POP: SP register is updated from alu_sp in WB; for POP, rd is written one
//   cycle after SP (second WB cycle). JMP: pc<=alu_out iff alu_branch; a taken
//   branch overrides the pc+2 updates from the fetch phase.
//  mem_ack outside FETCH/IMM/MEM is ignored. pc wraps 16'hFFFE+2 -> 16'h0000.
//  Reset mid-transaction: mem_req drops asynchronously; the bus must discard it.
// CONFIGURATION
//  ALU_SEQ_TRAP_EN defined: an opcode not in cpu_constants.vh sets fault (sticky
//   until rst) and the FSM parks in HALT (no mem_req, no alu_en).
//  Not defined: unknown opcodes run EXEC/WB with reg_we and flags_we forced to 0
//   (NOP); fault is tied to 0.
// STRUCTURE
//  Shared package cpu_constants.vh: OPC_* opcodes, FLAG_BIT_*, and the new
//   SEQ_ST_* state encodings plus INSTR_* field positions.
//  Sub-module alu_seq_decode (combinational): instr -> class bits
//   (is_mem, is_store, is_stack, sets_flags, legal).
// TESTING
//  ADD r1,r2 without immediate, mem_ack returned the cycle after req -> FETCH..WB
//   in 5 cycles; reg_we pulses once with rd=1, flags_we=1, pc=0x0002.
//  MOV r3,#0xBEEF -> two fetches (pc 0->4), immediate=0xBEEF, reg_wdata=0xBEEF.
//  ST with mem_ack delayed 3 cycles -> mem_req/mem_we/mem_addr stable for 4 cycles,
//   no reg_we.
//  JMP taken to 0x0100 (alu_branch=1) -> next FETCH mem_addr=0x0100; not taken ->
//   mem_addr=pc+2 or pc+4 with immediate.
//  PUSH r1 with SP=0x8000 -> mem write at 0x7FFE, SP written 0x7FFE; POP reads
//   0x7FFE, SP=0x8000, rd loaded.
//  rst asserted while in MEM -> outputs at reset values without a clock edge;
//   opcode 0xFF: fault=1 + HALT (TRAP_EN) or NOP with pc advancing by 2.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: d16 opcodes, flag bits, instruction field positions and sequencer state encodings.
package alu_sequencer_pkg;
   localparam logic [7:0] OPC_NOP  = 8'h00;
   localparam logic [7:0] OPC_MOV  = 8'h01;
   localparam logic [7:0] OPC_ADD  = 8'h02;
   localparam logic [7:0] OPC_SUB  = 8'h03;
   localparam logic [7:0] OPC_ADC  = 8'h04;
   localparam logic [7:0] OPC_SBB  = 8'h05;
   localparam logic [7:0] OPC_CMP  = 8'h06;
   localparam logic [7:0] OPC_AND  = 8'h07;
   localparam logic [7:0] OPC_OR   = 8'h08;
   localparam logic [7:0] OPC_XOR  = 8'h09;
   localparam logic [7:0] OPC_NOT  = 8'h0A;
   localparam logic [7:0] OPC_NEG  = 8'h0B;
   localparam logic [7:0] OPC_SHL  = 8'h0C;
   localparam logic [7:0] OPC_SHR  = 8'h0D;
   localparam logic [7:0] OPC_LD   = 8'h10;
   localparam logic [7:0] OPC_ST   = 8'h11;
   localparam logic [7:0] OPC_PUSH = 8'h12;
   localparam logic [7:0] OPC_POP  = 8'h13;
   localparam logic [7:0] OPC_JMP  = 8'h20;
   localparam int FLAG_BIT_Z = 0;
   localparam int FLAG_BIT_C = 1;
   localparam int FLAG_BIT_N = 2;
   localparam int FLAG_BIT_V = 3;
   localparam int INSTR_OPC_LSB  = 0;
   localparam int INSTR_IMM_BIT  = 8;
   localparam int INSTR_RS_LSB   = 9;
   localparam int INSTR_RD_LSB   = 12;
   localparam int INSTR_DISP_BIT = 15;
   typedef enum logic [2:0] {
      SEQ_ST_FETCH  = 3'd0,
      SEQ_ST_IMM    = 3'd1,
      SEQ_ST_EXEC   = 3'd2,
      SEQ_ST_RESULT = 3'd3,
      SEQ_ST_MEM    = 3'd4,
      SEQ_ST_WB     = 3'd5,
      SEQ_ST_WB2    = 3'd6,
      SEQ_ST_HALT   = 3'd7
   } seq_state_e;
   typedef struct packed {
      logic is_mem;
      logic is_store;
      logic is_stack;
      logic is_jmp;
      logic sets_flags;
      logic legal;
   } instr_class_t;
endpackage

// File: rtl/alu_sequencer_decode.sv
// alu_sequencer_decode: combinational opcode classifier for the sequencer.
module alu_sequencer_decode
   import alu_sequencer_pkg::*;
(
   input  logic [7:0]   opc_i,
   output instr_class_t cls_o
);
   always_comb begin
      cls_o            = '0;
      cls_o.is_mem     = opc_i inside {OPC_LD, OPC_ST, OPC_PUSH, OPC_POP};
      cls_o.is_store   = opc_i inside {OPC_ST, OPC_PUSH};
      cls_o.is_stack   = opc_i inside {OPC_PUSH, OPC_POP};
      cls_o.is_jmp     = opc_i == OPC_JMP;
      cls_o.sets_flags = opc_i inside {OPC_ADD, OPC_SUB, OPC_ADC, OPC_SBB, OPC_CMP, OPC_AND,
                                       OPC_OR, OPC_XOR, OPC_NOT, OPC_NEG, OPC_SHL, OPC_SHR};
      cls_o.legal      = cls_o.is_mem | cls_o.sets_flags | (opc_i inside {OPC_NOP, OPC_MOV, OPC_JMP});
   end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/execute/memory/write-back control FSM for the d16 core.
// ALU_SEQ_TRAP_EN: illegal opcodes set a sticky fault and park the FSM in HALT.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [2:0]  SP_REG   = 3'd7
)(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] mem_addr,
   output logic        mem_req,
   output logic        mem_we,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic        alu_en,
   output logic [7:0]  alu_control,
   output logic        en_imm,
   output logic        mem_disp,
   output logic [2:0]  rd_sel,
   output logic [2:0]  rs_sel,
   output logic [15:0] immediate,
   input  logic [15:0] alu_out,
   input  logic        alu_write,
   input  logic        alu_branch,
   input  logic [15:0] alu_sp,
   output logic        reg_we,
   output logic [2:0]  reg_wsel,
   output logic [15:0] reg_wdata,
   output logic        flags_we,
   output logic [15:0] pc,
   output logic        fault
);
   seq_state_e   state_q, state_d;
   logic [15:0]  pc_q, pc_d, instr_q, instr_d, imm_q, imm_d, rdata_q, rdata_d;
   logic         req_raw;
   instr_class_t cls;
   alu_sequencer_decode u_dec (
      .opc_i (instr_q[INSTR_OPC_LSB +: 8]),
      .cls_o (cls)
   );
   assign alu_control = instr_q[INSTR_OPC_LSB +: 8];
   assign en_imm      = instr_q[INSTR_IMM_BIT];
   assign mem_disp    = instr_q[INSTR_DISP_BIT];
   assign rd_sel      = instr_q[INSTR_RD_LSB +: 3];
   assign rs_sel      = cls.is_stack ? SP_REG : instr_q[INSTR_RS_LSB +: 3];
   assign immediate   = imm_q;
   assign pc          = pc_q;
   // Gate with rst so the bus sees the request drop without waiting for a clock.
   assign mem_req     = req_raw & ~rst;
`ifdef ALU_SEQ_TRAP_EN
   logic fault_q, fault_d;
   assign fault = fault_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) fault_q <= 1'b0;
      else     fault_q <= fault_d;
`else
   assign fault = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= SEQ_ST_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         imm_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         imm_q   <= imm_d;
         rdata_q <= rdata_d;
      end
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      imm_d     = imm_q;
      rdata_d   = rdata_q;
      req_raw   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;
      alu_en    = 1'b0;
      reg_we    = 1'b0;
      reg_wsel  = rd_sel;
      reg_wdata = alu_out;
      flags_we  = 1'b0;
`ifdef ALU_SEQ_TRAP_EN
      fault_d   = fault_q;
`endif
      case (state_q)
         SEQ_ST_FETCH: begin
            req_raw = 1'b1;
            if (mem_ack) begin
               instr_d = mem_rdata;
               pc_d    = pc_q + 16'd2;
               state_d = mem_rdata[INSTR_IMM_BIT] ? SEQ_ST_IMM : SEQ_ST_EXEC;
            end
         end
         SEQ_ST_IMM: begin
            req_raw = 1'b1;
            if (mem_ack) begin
               imm_d   = mem_rdata;
               pc_d    = pc_q + 16'd2;
               state_d = SEQ_ST_EXEC;
            end
         end
         SEQ_ST_EXEC: begin
`ifdef ALU_SEQ_TRAP_EN
            alu_en  = cls.legal;
            fault_d = fault_q | ~cls.legal;
            state_d = cls.legal ? SEQ_ST_RESULT : SEQ_ST_HALT;
`else
            alu_en  = 1'b1;
            state_d = SEQ_ST_RESULT;
`endif
         end
         SEQ_ST_RESULT: state_d = cls.is_mem ? SEQ_ST_MEM : SEQ_ST_WB;
         SEQ_ST_MEM: begin
            req_raw  = 1'b1;
            mem_addr = alu_out;
            mem_we   = cls.is_store;
            if (mem_ack) begin
               rdata_d = mem_rdata;
               state_d = SEQ_ST_WB;
            end
         end
         SEQ_ST_WB: begin
            flags_we  = cls.sets_flags;
            reg_we    = cls.is_stack | (alu_write & cls.legal & ~cls.is_store);
            reg_wsel  = cls.is_stack ? SP_REG : rd_sel;
            reg_wdata = cls.is_stack ? alu_sp : (cls.is_mem ? rdata_q : alu_out);
            // POP loads rd one cycle after the SP update.
            state_d   = (cls.is_stack & ~cls.is_store) ? SEQ_ST_WB2 : SEQ_ST_FETCH;
            pc_d      = (cls.is_jmp & alu_branch) ? alu_out : pc_q;
         end
         SEQ_ST_WB2: begin
            reg_we    = alu_write;
            reg_wdata = rdata_q;
            state_d   = SEQ_ST_FETCH;
         end
         SEQ_ST_HALT: state_d = SEQ_ST_HALT;
         default: state_d = SEQ_ST_FETCH;
      endcase
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench; a memory responder and a write-back monitor check queued expectations.
module tb_alu_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] mem_addr, mem_rdata = '0;
   logic        mem_req, mem_we, mem_ack = 1'b0;
   logic        alu_en, en_imm, mem_disp, reg_we, flags_we, fault;
   logic [7:0]  alu_control;
   logic [2:0]  rd_sel, rs_sel, reg_wsel;
   logic [15:0] immediate, reg_wdata, pc;
   logic [15:0] alu_out = '0, alu_sp = '0;
   logic        alu_write = 1'b0, alu_branch = 1'b0;
   int tests = 0, fails = 0, alu_en_n = 0;
   int wait_cnt = 0, req_cnt = 0;
   logic unstable = 1'b0;
   typedef struct { logic [15:0] addr; logic we; logic [15:0] data; int dly; int cyc; } mem_t;
   typedef struct { logic [2:0] sel; logic [15:0] data; logic fl; } rw_t;
   mem_t sb_mem[$];
   rw_t  sb_reg[$];
   alu_sequencer dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .alu_en(alu_en), .alu_control(alu_control),
      .en_imm(en_imm), .mem_disp(mem_disp), .rd_sel(rd_sel), .rs_sel(rs_sel),
      .immediate(immediate), .alu_out(alu_out), .alu_write(alu_write), .alu_branch(alu_branch),
      .alu_sp(alu_sp), .reg_we(reg_we), .reg_wsel(reg_wsel), .reg_wdata(reg_wdata),
      .flags_we(flags_we), .pc(pc), .fault(fault)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      mem_t e;
      if (rst) begin
         mem_ack = 1'b0; wait_cnt = 0; req_cnt = 0; unstable = 1'b0;
         sb_mem.delete();
      end else if (mem_ack) mem_ack = 1'b0;
      else if (mem_req && sb_mem.size() != 0) begin
         req_cnt++;
         if (mem_addr !== sb_mem[0].addr || mem_we !== sb_mem[0].we) unstable = 1'b1;
         if (wait_cnt < sb_mem[0].dly) wait_cnt++;
         else begin
            e = sb_mem.pop_front();
            check("mem_addr", mem_addr, e.addr);
            check("mem_we", mem_we, e.we);
            if (e.cyc != 0) begin
               check("req_cycles", req_cnt, e.cyc);
               check("req_stable", unstable, 0);
            end
            mem_rdata = e.data; mem_ack = 1'b1;
            wait_cnt = 0; req_cnt = 0; unstable = 1'b0;
         end
      end
   end
   always @(negedge clk) begin
      rw_t r;
      if (alu_en) alu_en_n++;
      if (reg_we) begin
         if (sb_reg.size() == 0) check("unexpected_reg_we", {13'd0, reg_wsel}, 32'hFFFF_FFFF);
         else begin
            r = sb_reg.pop_front();
            check("reg_wsel", reg_wsel, r.sel);
            check("reg_wdata", reg_wdata, r.data);
            check("flags_we", flags_we, r.fl);
         end
      end
   end
   task automatic fetch(input logic [15:0] a, input logic [15:0] w);
      sb_mem.push_back('{a, 1'b0, w, 1, 0});
   endtask
   task automatic exp_wb(input logic [2:0] s, input logic [15:0] d, input logic f);
      sb_reg.push_back('{s, d, f});
   endtask
   task automatic alu(input logic [15:0] o, input logic w, input logic b, input logic [15:0] sp);
      alu_out = o; alu_write = w; alu_branch = b; alu_sp = sp;
   endtask
   task automatic wait_idle(input string tag);
      logic done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk); #1;
         done = (sb_mem.size() == 0) && mem_req && !mem_ack;
      end
      check({"idle_", tag}, done, 1);
   endtask
   initial begin
      logic hit = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_mem_req", mem_req, 0);
      check("rst_pc", pc, 16'h0000);
      check("rst_imm", immediate, 16'h0000);
      check("rst_fault", fault, 0);
      check("rst_strobes", {alu_en, reg_we, flags_we}, 3'b000);
      @(negedge clk); #2 rst = 1'b0;
      // ADD r1,r2
      alu(16'h0055, 1, 0, 0);
      sb_mem.push_back('{16'h0000, 1'b0, 16'h1402, 1, 2});
      exp_wb(3'd1, 16'h0055, 1);
      wait_idle("add");
      check("add_pc", pc, 16'h0002);
      check("add_sel", {rd_sel, rs_sel}, {3'd1, 3'd2});
      check("add_alu_en_once", alu_en_n, 1);
      // MOV r3,#0xBEEF
      alu(16'hBEEF, 1, 0, 0);
      fetch(16'h0002, 16'h3101); fetch(16'h0004, 16'hBEEF);
      exp_wb(3'd3, 16'hBEEF, 0);
      wait_idle("mov");
      check("mov_imm", immediate, 16'hBEEF);
      check("mov_pc", pc, 16'h0006);
      // ST with 3-cycle ack delay
      alu(16'h1234, 0, 0, 0);
      fetch(16'h0006, 16'h0211);
      sb_mem.push_back('{16'h1234, 1'b1, 16'h0000, 3, 4});
      wait_idle("st");
      check("st_pc", pc, 16'h0008);
      // LD r4,[rS+imm-less disp]
      alu(16'h2000, 1, 0, 0);
      fetch(16'h0008, 16'hC210);
      sb_mem.push_back('{16'h2000, 1'b0, 16'hCAFE, 1, 0});
      exp_wb(3'd4, 16'hCAFE, 0);
      wait_idle("ld");
      check("ld_disp", mem_disp, 1);
      // JMP #0x0100 taken
      alu(16'h0100, 0, 1, 0);
      fetch(16'h000A, 16'h0120); fetch(16'h000C, 16'h0100);
      wait_idle("jmp_t");
      check("jmp_t_addr", mem_addr, 16'h0100);
      check("jmp_t_ctl", {en_imm, alu_control}, 9'h120);
      // JMP not taken
      alu(16'h0200, 0, 0, 0);
      fetch(16'h0100, 16'h0020);
      wait_idle("jmp_n");
      check("jmp_n_addr", mem_addr, 16'h0102);
      // PUSH r1, SP 0x8000 -> 0x7FFE
      alu(16'h7FFE, 0, 0, 16'h7FFE);
      fetch(16'h0102, 16'h0212);
      sb_mem.push_back('{16'h7FFE, 1'b1, 16'h0000, 1, 0});
      exp_wb(3'd7, 16'h7FFE, 0);
      wait_idle("push");
      check("push_rs_sp", rs_sel, 3'd7);
      // POP r5
      alu(16'h7FFE, 1, 0, 16'h8000);
      fetch(16'h0104, 16'h5013);
      sb_mem.push_back('{16'h7FFE, 1'b0, 16'h1111, 1, 0});
      exp_wb(3'd7, 16'h8000, 0); exp_wb(3'd5, 16'h1111, 0);
      wait_idle("pop");
      check("pop_pc", pc, 16'h0106);
      // SUB r2,r3
      alu(16'h0001, 1, 0, 0);
      fetch(16'h0106, 16'h2603);
      exp_wb(3'd2, 16'h0001, 1);
      wait_idle("sub");
      // JMP to 0xFFFE, then NOP wraps pc to 0
      alu(16'hFFFE, 0, 1, 0);
      fetch(16'h0108, 16'h0020);
      wait_idle("jmp_w");
      alu(16'h0000, 0, 0, 0);
      fetch(16'hFFFE, 16'h0000);
      wait_idle("wrap");
      check("wrap_pc", pc, 16'h0000);
      check("wrap_addr", mem_addr, 16'h0000);
      // reset while ST waits in the memory phase
      alu(16'h3000, 0, 0, 0);
      fetch(16'h0000, 16'h0211);
      sb_mem.push_back('{16'h3000, 1'b1, 16'h0000, 100, 0});
      for (int i = 0; i < 30 && !hit; i++) begin
         @(negedge clk); #1;
         hit = mem_req && mem_we;
      end
      check("mem_phase_reached", hit, 1);
      #2 rst = 1'b1;
      #1;
      check("async_mem_req", mem_req, 0);
      check("async_pc", pc, 16'h0000);
      check("async_imm", immediate, 16'h0000);
      @(negedge clk); #2 rst = 1'b0;
      // opcode 0xFF
      alu(16'h9999, 1, 0, 0);
      fetch(16'h0000, 16'h00FF);
`ifdef ALU_SEQ_TRAP_EN
      repeat (12) @(negedge clk);
      #1;
      check("trap_fault", fault, 1);
      check("trap_halt_req", mem_req, 0);
      check("trap_alu_en_n", alu_en_n, 12);
`else
      wait_idle("illegal");
      check("nop_pc", pc, 16'h0002);
      check("nop_fault", fault, 0);
      check("nop_alu_en_n", alu_en_n, 13);
`endif
      check("mem_sb_empty", sb_mem.size(), 0);
      check("reg_sb_empty", sb_reg.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
